// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer running from the free-running reference clock.
// Define PLL_RESET_SEQ_STATS_EN to expose the retry_cnt and loss_cnt statistics counters.

module pll_reset_sequencer_chk (
    input logic clk,
    input logic rst,
    input logic pll_rst,
    input logic sys_rst_n,
    input logic ready,
    input logic fail
);
    ap_ready_implies_released: assert property (@(posedge clk) disable iff (!rst) ready |-> sys_rst_n);
    ap_fail_quiet: assert property (@(posedge clk) disable iff (!rst) fail |-> (!pll_rst && !sys_rst_n));
    ap_no_release_in_pll_rst: assert property (@(posedge clk) disable iff (!rst) !(pll_rst && sys_rst_n));
endmodule

module pll_reset_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int HOLDOFF      = 32,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             soft_rst_req,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLDOFF   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int SB_W = $clog2(LOCK_STABLE + 1);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int HO_W = $clog2(HOLDOFF + 1);
`ifdef PLL_RESET_SEQ_STATS_EN
    localparam int RT_W = CNT_W;
`else
    localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
`endif

    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(RST_CYCLES);
    localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
    localparam logic [SB_W-1:0] SB_MAX  = SB_W'(LOCK_STABLE);
    localparam logic [SB_W-1:0] SB_ONE  = SB_W'(1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(LOCK_TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [HO_W-1:0] HO_MAX  = HO_W'(HOLDOFF);
    localparam logic [HO_W-1:0] HO_ONE  = HO_W'(1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);
    localparam logic [RT_W-1:0] RT_ONE  = RT_W'(1);

    state_t          state_d, state_q;
    logic [RC_W-1:0] rc_d, rc_q, rc_inc;
    logic [SB_W-1:0] stab_d, stab_q, stab_inc;
    logic [TO_W-1:0] tmo_d, tmo_q, tmo_inc;
    logic [HO_W-1:0] hold_d, hold_q, hold_inc;
    logic [RT_W-1:0] retry_cnt_d, retry_cnt_q;
    logic            pll_rst_d, pll_rst_q;
    logic            sys_rst_n_d, sys_rst_n_q;
    logic            ready_d, ready_q;
    logic            fail_d, fail_q;
    logic            meta_q, locked_q;
    logic            locked_s;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            meta_q   <= pll_locked;
            locked_q <= meta_q;
        end
    end

    assign locked_s = locked_q;
    assign rc_inc   = rc_q + RC_ONE;
    assign stab_inc = stab_q + SB_ONE;
    assign tmo_inc  = tmo_q + TO_ONE;
    assign hold_inc = hold_q + HO_ONE;

    // Sequencer next-state and counter update; a soft request overrides everything.
    always_comb begin
        state_d     = state_q;
        rc_d        = rc_q;
        stab_d      = stab_q;
        tmo_d       = tmo_q;
        hold_d      = hold_q;
        retry_cnt_d = retry_cnt_q;
        if (soft_rst_req) begin
            state_d     = ST_PLL_RST;
            rc_d        = {RC_W{1'b0}};
            stab_d      = {SB_W{1'b0}};
            tmo_d       = {TO_W{1'b0}};
            hold_d      = {HO_W{1'b0}};
            retry_cnt_d = {RT_W{1'b0}};
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    stab_d = {SB_W{1'b0}};
                    tmo_d  = {TO_W{1'b0}};
                    if (rc_inc == RC_MAX) begin
                        state_d = ST_WAIT_LOCK;
                        rc_d    = {RC_W{1'b0}};
                    end else begin
                        rc_d = rc_inc;
                    end
                end
                ST_WAIT_LOCK: begin
                    tmo_d = tmo_inc;
                    if (locked_s) begin
                        stab_d = stab_inc;
                    end else begin
                        stab_d = {SB_W{1'b0}};
                    end
                    // Stable lock takes precedence over a coincident timeout.
                    if (locked_s && (stab_inc == SB_MAX)) begin
                        state_d = ST_HOLDOFF;
                        hold_d  = {HO_W{1'b0}};
                    end else if (tmo_inc == TO_MAX) begin
                        if (retry_cnt_q == RT_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d     = ST_PLL_RST;
                            rc_d        = {RC_W{1'b0}};
                            retry_cnt_d = retry_cnt_q + RT_ONE;
                        end
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_HOLDOFF: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        stab_d  = {SB_W{1'b0}};
                        tmo_d   = {TO_W{1'b0}};
                    end else if (hold_inc == HO_MAX) begin
                        state_d     = ST_RUN;
                        retry_cnt_d = {RT_W{1'b0}};
                    end else begin
                        hold_d = hold_inc;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        stab_d  = {SB_W{1'b0}};
                        tmo_d   = {TO_W{1'b0}};
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_PLL_RST;
                    rc_d    = {RC_W{1'b0}};
                end
            endcase
        end
    end

    // Output levels are decoded from the next state so they can be registered.
    always_comb begin
        pll_rst_d   = 1'b0;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
        fail_d      = 1'b0;
        case (state_d)
            ST_PLL_RST:   pll_rst_d = 1'b1;
            ST_WAIT_LOCK: pll_rst_d = 1'b0;
            ST_HOLDOFF:   pll_rst_d = 1'b0;
            ST_RUN: begin
                sys_rst_n_d = 1'b1;
                ready_d     = 1'b1;
            end
            ST_FAIL:      fail_d = 1'b1;
            default:      pll_rst_d = 1'b1;
        endcase
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_PLL_RST;
            rc_q        <= {RC_W{1'b0}};
            stab_q      <= {SB_W{1'b0}};
            tmo_q       <= {TO_W{1'b0}};
            hold_q      <= {HO_W{1'b0}};
            retry_cnt_q <= {RT_W{1'b0}};
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            stab_q      <= stab_d;
            tmo_q       <= tmo_d;
            hold_q      <= hold_d;
            retry_cnt_q <= retry_cnt_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;

`ifdef PLL_RESET_SEQ_STATS_EN
    localparam logic [CNT_W-1:0] LOSS_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LOSS_ONE = CNT_W'(1);

    logic             loss_event_s;
    logic [CNT_W-1:0] loss_cnt_d, loss_cnt_q;

    assign loss_event_s = (state_q == ST_RUN) && !locked_s && !soft_rst_req;

    // Saturating lock-loss count; deliberately survives soft restarts.
    always_comb begin
        if (loss_event_s && (loss_cnt_q != LOSS_MAX)) begin
            loss_cnt_d = loss_cnt_q + LOSS_ONE;
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
    end

    // Lock-loss counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loss_cnt_q <= {CNT_W{1'b0}};
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign retry_cnt = retry_cnt_q;
    assign loss_cnt  = loss_cnt_q;
`else
    assign retry_cnt = {CNT_W{1'b0}};
    assign loss_cnt  = {CNT_W{1'b0}};
`endif

    pll_reset_sequencer_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .pll_rst   (pll_rst_q),
        .sys_rst_n (sys_rst_n_q),
        .ready     (ready_q),
        .fail      (fail_q)
    );
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: edge-history reference model plus directed scenarios.
module tb_pll_reset_sequencer;
    localparam int P_RST_CYC = 4;
    localparam int P_STABLE  = 8;
    localparam int P_TIMEOUT = 50;
    localparam int P_HOLDOFF = 5;
    localparam int P_RETRIES = 2;
    localparam int P_CNT_W   = 8;
    localparam int HMAX      = 2048;
`ifdef PLL_RESET_SEQ_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif
    localparam int P_RST = 0, P_WAIT = 1, P_HOLD = 2, P_RUN = 3, P_FAIL = 4;

    logic               clk = 1'b0;
    logic               rst, pll_locked, soft_rst_req;
    logic               pll_rst, sys_rst_n, ready, fail;
    logic [P_CNT_W-1:0] retry_cnt, loss_cnt;

    int n_checks = 0;
    int n_err    = 0;

    pll_reset_sequencer #(
        .RST_CYCLES(P_RST_CYC), .LOCK_STABLE(P_STABLE), .LOCK_TIMEOUT(P_TIMEOUT),
        .HOLDOFF(P_HOLDOFF), .MAX_RETRIES(P_RETRIES), .CNT_W(P_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    always #10 clk = ~clk;

    // Input history captured at every rising edge, indexed by edge number.
    int   ecnt = 0;
    logic hist_lk  [0:HMAX-1];
    logic hist_sr  [0:HMAX-1];
    logic hist_rst [0:HMAX-1];

    always @(posedge clk) begin
        if (ecnt < HMAX) begin
            hist_lk[ecnt]  <= pll_locked;
            hist_sr[ecnt]  <= soft_rst_req;
            hist_rst[ecnt] <= rst;
        end
        ecnt <= ecnt + 1;
    end

    // Reference model: phase plus the edge at which it was entered.
    int m_phase = P_RST, m_t0 = 0, m_rel = 0, m_retry = 0, m_loss = 0, m_done = 0;
    bit m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int e);
        m_phase = P_RST; m_t0 = e; m_rel = e; m_retry = 0; m_loss = 0; m_valid = 1'b1;
    endtask

    // Lock level seen by the sequencer at edge e: input sampled two edges earlier, zero near reset.
    function automatic logic ls(input int e);
        if (e - 2 > m_rel) return hist_lk[e-2];
        return 1'b0;
    endfunction

    task automatic step(input int e);
        int run;
        int k;
        if (hist_rst[e] == 1'b0) begin
            do_reset(e);
        end else if (hist_sr[e]) begin
            m_phase = P_RST; m_t0 = e; m_retry = 0;
        end else begin
            case (m_phase)
                P_RST: if (e - m_t0 == P_RST_CYC) begin m_phase = P_WAIT; m_t0 = e; end
                P_WAIT: begin
                    run = 0;
                    k = e;
                    while (k > m_t0 && ls(k)) begin run++; k--; end
                    if (run >= P_STABLE) begin
                        m_phase = P_HOLD; m_t0 = e;
                    end else if (e - m_t0 == P_TIMEOUT) begin
                        if (m_retry == P_RETRIES) m_phase = P_FAIL;
                        else begin m_retry++; m_phase = P_RST; m_t0 = e; end
                    end
                end
                P_HOLD: begin
                    if (!ls(e)) begin m_phase = P_WAIT; m_t0 = e; end
                    else if (e - m_t0 == P_HOLDOFF) begin m_phase = P_RUN; m_retry = 0; end
                end
                P_RUN: if (!ls(e)) begin
                    m_phase = P_WAIT; m_t0 = e;
                    if (m_loss < 255) m_loss++;
                end
                default: ;
            endcase
        end
    endtask

    // Advance the model on the falling edge and compare every output against it.
    initial begin
        forever begin
            @(negedge clk);
            while (m_done < ecnt && m_done < HMAX) begin step(m_done); m_done++; end
            if (rst == 1'b0) do_reset(ecnt - 1);
            if (m_valid) begin
                chk("pll_rst",   pll_rst,   32'(m_phase == P_RST));
                chk("sys_rst_n", sys_rst_n, 32'(m_phase == P_RUN));
                chk("ready",     ready,     32'(m_phase == P_RUN));
                chk("fail",      fail,      32'(m_phase == P_FAIL));
                chk("retry_cnt", retry_cnt, 32'(STATS != 0 ? m_retry : 0));
                chk("loss_cnt",  loss_cnt,  32'(STATS != 0 ? m_loss : 0));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int cur_edge();
        return ecnt - 1;
    endfunction

    task automatic wait_out(input string name, input int sel, input logic val, input int bound, output int e);
        logic v;
        e = -1;
        for (int i = 0; i < bound && e < 0; i++) begin
            tick();
            v = (sel == 0) ? sys_rst_n : fail;
            if (v === val) e = cur_edge();
        end
        if (e < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: no transition within %0d cycles", name, bound);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e, t, saw;
        rst = 1'b1; pll_locked = 1'b0; soft_rst_req = 1'b0;
        #2 rst = 1'b0;
        #2;
        chk("rst_pll_rst", pll_rst, 1); chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_ready", ready, 0); chk("rst_fail", fail, 0);
        chk("rst_retry", retry_cnt, 0); chk("rst_loss", loss_cnt, 0);
        tick(); tick();

        // Power-up: lock from edge 10, release expected at edge 25.
        e0 = cur_edge();
        rst = 1'b1;
        while (cur_edge() < e0 + 3) tick();
        chk("pll_rst_edge3", pll_rst, 1);
        tick();
        chk("pll_rst_edge4", pll_rst, 0);
        while (cur_edge() < e0 + 10) tick();
        pll_locked = 1'b1;
        wait_out("lock_release", 0, 1'b1, 60, e);
        chk("lock_release_edge", 32'(e - e0), 25);
        chk("lock_ready", ready, 1);
        chk("lock_retry", retry_cnt, 0);

        // Lock loss in RUN, then relock.
        tick(); tick(); tick();
        t = cur_edge();
        pll_locked = 1'b0;
        wait_out("loss_detect", 0, 1'b0, 20, e);
        chk("loss_latency", 32'(e - t), 3);
        chk("loss_ready", ready, 0);
        chk("loss_count", loss_cnt, 32'(STATS != 0 ? 1 : 0));
        t = cur_edge();
        pll_locked = 1'b1;
        wait_out("relock", 0, 1'b1, 40, e);
        chk("relock_edges", 32'(e - t), 15);

        // Lock never returns: three timeouts lead to FAIL.
        tick(); tick(); tick();
        t = cur_edge();
        pll_locked = 1'b0;
        wait_out("fail_entry", 1, 1'b1, 300, e);
        chk("fail_edge", 32'(e - t), 161);
        chk("fail_pll_rst", pll_rst, 0);
        chk("fail_sys_rst_n", sys_rst_n, 0);
        chk("fail_retry", retry_cnt, 32'(STATS != 0 ? 2 : 0));
        repeat (10) tick();
        chk("fail_sticky", fail, 1);

        // Soft restart out of FAIL.
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        chk("soft_fail_clr", fail, 0);
        chk("soft_pll_rst", pll_rst, 1);
        chk("soft_retry", retry_cnt, 0);
        chk("soft_loss_kept", loss_cnt, 32'(STATS != 0 ? 1 : 0));
        tick(); tick(); tick();
        chk("soft_pll_rst_c4", pll_rst, 1);
        tick();
        chk("soft_pll_rst_end", pll_rst, 0);

        // Lock pulses of 6 cycles never qualify; retries run out.
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            pll_locked = 1'b1;
            for (int j = 0; j < 6; j++) begin tick(); if (sys_rst_n !== 1'b0) saw = 1; end
            pll_locked = 1'b0;
            for (int j = 0; j < 4; j++) begin tick(); if (sys_rst_n !== 1'b0) saw = 1; end
        end
        chk("toggle_no_release", 32'(saw), 0);
        chk("toggle_fail", fail, 1);

        // Async reset in the middle of HOLDOFF.
        pll_locked = 1'b1;
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        for (int i = 0; i < 60 && m_phase != P_HOLD; i++) tick();
        if (m_phase != P_HOLD) begin
            n_checks++; n_err++;
            $display("FAIL holdoff_reach: model phase %0d, expected %0d", m_phase, P_HOLD);
        end
        tick();
        chk("pre_rst_pll_rst", pll_rst, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_pll_rst", pll_rst, 1); chk("async_sys_rst_n", sys_rst_n, 0);
        chk("async_ready", ready, 0); chk("async_fail", fail, 0);
        chk("async_loss", loss_cnt, 0);
        tick(); tick();
        e0 = cur_edge();
        rst = 1'b1;
        wait_out("post_rst_release", 0, 1'b1, 60, e);
        chk("post_rst_release_edge", 32'(e - e0), 17);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
